game_session_ctrl: RTL and testbench

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

---
 rtl/game_session_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_game_session_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_session_ctrl.sv
// Game session controller: menu/wait/play/victory/game-over sequencing, hit points, invulnerability, BCD score.
// Latency: every transition and counter update is registered, one clk after the qualifying input; frame tick lags a vsync rise by one cycle.
// Backpressure: none; inputs are sampled every cycle. Optional macro GAME_SESSION_CTRL_HIT_LOG_EN adds the hit_log output.
module game_session_ctrl #(
  parameter int N_OBST        = 4,
  parameter int HP_MAX        = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int PLAY_FRAMES   = 1800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_single,
  input  logic              start_multi,
  input  logic              menu_req,
  input  logic              vsync_in,
  input  logic [N_OBST-1:0] hit_vec,
  input  logic              opponent_ready,
  input  logic              opponent_over,
  output logic [2:0]        state,
  output logic              play_active,
  output logic              player_ready,
  output logic              multiplayer,
  output logic              victory,
  output logic              game_over,
  output logic              invuln,
  output logic [3:0]        hp,
  output logic [15:0]       score_bcd
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
  ,
  output logic [N_OBST-1:0] hit_log
`endif
);

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_WAIT_OPP  = 3'd1,
    S_PLAY      = 3'd2,
    S_VICTORY   = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        mp_q, mp_d;
  logic [3:0]  hp_q, hp_d;
  logic [15:0] score_q, score_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        vs_q, vs_prev_q;
  logic        play_active_q, player_ready_q, victory_q, game_over_q;
  logic        frame_tick, in_play, hit, play_entry;
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
  logic [N_OBST-1:0] hit_log_q, hit_log_d;
`endif

  // Four-digit BCD increment with carry, pinned at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign frame_tick = vs_q & ~vs_prev_q;
  assign in_play    = (state_q == S_PLAY);
  assign hit        = in_play && (inv_cnt_q == 8'd0) && (|hit_vec);
  assign play_entry = (state_d == S_PLAY) && !in_play;

  // Next-state logic for the session FSM and the multiplayer mode latch.
  always_comb begin
    state_d = state_q;
    mp_d    = mp_q;
    case (state_q)
      S_MENU: begin
        if (start_single) begin
          state_d = S_PLAY;
          mp_d    = 1'b0;
        end else if (start_multi) begin
          state_d = S_WAIT_OPP;
          mp_d    = 1'b1;
        end
      end
      S_WAIT_OPP: begin
        if (menu_req)            state_d = S_MENU;
        else if (opponent_ready) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (menu_req)          state_d = S_MENU;
        else if (hp_q == 4'd0) state_d = S_GAME_OVER;
        else if ((frame_q == 16'(PLAY_FRAMES)) || (mp_q && opponent_over))
          state_d = S_VICTORY;
      end
      S_VICTORY, S_GAME_OVER: begin
        if (menu_req) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase
  end

  // Hit points, invulnerability countdown, frame count and score; PLAY entry reloads them.
  always_comb begin
    hp_d      = hp_q;
    score_d   = score_q;
    frame_d   = frame_q;
    inv_cnt_d = inv_cnt_q;
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
    hit_log_d = hit_log_q;
`endif
    if (hit) begin
      hp_d      = (hp_q == 4'd0) ? 4'd0 : hp_q - 4'd1;
      inv_cnt_d = 8'(INVULN_FRAMES);
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
      hit_log_d = hit_log_q | hit_vec;
`endif
    end else if (frame_tick && (inv_cnt_q != 8'd0)) begin
      inv_cnt_d = inv_cnt_q - 8'd1;
    end
    if (in_play && frame_tick) begin
      frame_d = frame_q + 16'd1;
      score_d = bcd_inc(score_q);
    end
    if (play_entry) begin
      hp_d      = 4'(HP_MAX);
      score_d   = 16'd0;
      frame_d   = 16'd0;
      inv_cnt_d = 8'd0;
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
      hit_log_d = '0;
`endif
    end
  end

  // State, datapath, vsync history and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_MENU;
      mp_q           <= 1'b0;
      hp_q           <= 4'(HP_MAX);
      score_q        <= 16'd0;
      frame_q        <= 16'd0;
      inv_cnt_q      <= 8'd0;
      vs_q           <= 1'b0;
      vs_prev_q      <= 1'b0;
      play_active_q  <= 1'b0;
      player_ready_q <= 1'b0;
      victory_q      <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mp_q           <= mp_d;
      hp_q           <= hp_d;
      score_q        <= score_d;
      frame_q        <= frame_d;
      inv_cnt_q      <= inv_cnt_d;
      vs_q           <= vsync_in;
      vs_prev_q      <= vs_q;
      play_active_q  <= (state_d == S_PLAY);
      player_ready_q <= ((state_d == S_WAIT_OPP) || (state_d == S_PLAY)) && mp_d;
      victory_q      <= (state_d == S_VICTORY);
      game_over_q    <= (state_d == S_GAME_OVER);
    end
  end

`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
  // Sticky record of the channels that caused damage this game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_log_q <= '0;
    else     hit_log_q <= hit_log_d;
  end
  assign hit_log = hit_log_q;
`endif

  assign state        = state_q;
  assign play_active  = play_active_q;
  assign player_ready = player_ready_q;
  assign multiplayer  = mp_q;
  assign victory      = victory_q;
  assign game_over    = game_over_q;
  assign invuln       = (inv_cnt_q != 8'd0);
  assign hp           = hp_q;
  assign score_bcd    = score_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Bench for game_session_ctrl: directed scenarios and random play against a behavioural model,
// plus a long-game instance for score carry and saturation.
module tb_game_session_ctrl;

  localparam int HPM = 3;
  localparam int IF_ = 2;
  localparam int PF  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic rst, ss, sm, menu, vs, oready, oover;
  logic [3:0] hit;
  logic [2:0] state;
  logic play_active, player_ready, multiplayer, victory, game_over, invuln;
  logic [3:0] hp;
  logic [15:0] score_bcd;
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
  logic [3:0] hit_log;
  logic [3:0] hit_log2;
`endif

  // Long-game instance signals
  logic rst2, ss2, vs2, zero1;
  logic [3:0] zero4;
  logic [2:0] state2;
  logic pa2, pr2, mp2, vic2, go2, inv2;
  logic [3:0] hp2;
  logic [15:0] score2;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  game_session_ctrl #(.N_OBST(4), .HP_MAX(HPM), .INVULN_FRAMES(IF_), .PLAY_FRAMES(PF)) u_dut (
    .clk(clk), .rst(rst), .start_single(ss), .start_multi(sm), .menu_req(menu),
    .vsync_in(vs), .hit_vec(hit), .opponent_ready(oready), .opponent_over(oover),
    .state(state), .play_active(play_active), .player_ready(player_ready),
    .multiplayer(multiplayer), .victory(victory), .game_over(game_over),
    .invuln(invuln), .hp(hp), .score_bcd(score_bcd)
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
    , .hit_log(hit_log)
`endif
  );

  game_session_ctrl #(.N_OBST(4), .HP_MAX(HPM), .INVULN_FRAMES(IF_), .PLAY_FRAMES(12000)) u_big (
    .clk(clk), .rst(rst2), .start_single(ss2), .start_multi(zero1), .menu_req(zero1),
    .vsync_in(vs2), .hit_vec(zero4), .opponent_ready(zero1), .opponent_over(zero1),
    .state(state2), .play_active(pa2), .player_ready(pr2), .multiplayer(mp2),
    .victory(vic2), .game_over(go2), .invuln(inv2), .hp(hp2), .score_bcd(score2)
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
    , .hit_log(hit_log2)
`endif
  );

  // Behavioural model: states as plain integers 0..4, score as a decimal integer.
  int m_state, m_hp, m_score, m_fr, m_inv;
  bit m_mp, m_v1, m_v2;
  logic [3:0] m_log;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int ns, nhp, nsc, nfr, ninv;
    bit nmp, tick, hitc;
    logic [3:0] nlog;
    if (rst) begin
      m_state <= 0; m_hp <= HPM; m_score <= 0; m_fr <= 0; m_inv <= 0;
      m_mp <= 1'b0; m_v1 <= 1'b0; m_v2 <= 1'b0; m_log <= 4'd0;
    end else begin
      tick = m_v1 && !m_v2;
      ns = m_state; nmp = m_mp; nhp = m_hp; nsc = m_score; nfr = m_fr; ninv = m_inv; nlog = m_log;
      case (m_state)
        0: if (ss) begin ns = 2; nmp = 1'b0; end
           else if (sm) begin ns = 1; nmp = 1'b1; end
        1: if (menu) ns = 0; else if (oready) ns = 2;
        2: if (menu) ns = 0;
           else if (m_hp == 0) ns = 4;
           else if (m_fr == PF || (m_mp && oover)) ns = 3;
        default: if (menu) ns = 0;
      endcase
      hitc = (m_state == 2) && (m_inv == 0) && (hit != 4'd0);
      if (hitc) begin
        nhp = (m_hp > 0) ? m_hp - 1 : 0;
        ninv = IF_;
        nlog = m_log | hit;
      end else if (tick && m_inv > 0) begin
        ninv = m_inv - 1;
      end
      if (m_state == 2 && tick) begin
        nfr = nfr + 1;
        if (nsc < 9999) nsc = nsc + 1;
      end
      if (ns == 2 && m_state != 2) begin
        nhp = HPM; nsc = 0; nfr = 0; ninv = 0; nlog = 4'd0;
      end
      m_state <= ns; m_mp <= nmp; m_hp <= nhp; m_score <= nsc; m_fr <= nfr;
      m_inv <= ninv; m_log <= nlog; m_v2 <= m_v1; m_v1 <= vs;
    end
  end

  // Per-cycle comparison of every main-instance output against the model.
  always @(negedge clk) begin
    logic [28:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {3'(m_state), (m_state == 2), ((m_state == 1 || m_state == 2) && m_mp), m_mp,
               (m_state == 3), (m_state == 4), (m_inv > 0), 4'(m_hp), to_bcd(m_score)};
      act_v = {state, play_active, player_ready, multiplayer, victory, game_over, invuln, hp, score_bcd};
      n_checks++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, act_v, exp_v);
      end
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
      n_checks++;
      if (hit_log !== m_log) begin
        n_err++;
        $display("FAIL hit_log_cmp t=%0t got=%h expected=%h", $time, hit_log, m_log);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_ss();     ss = 1'b1;   @(negedge clk); ss = 1'b0;   endtask
  task automatic pulse_sm();     sm = 1'b1;   @(negedge clk); sm = 1'b0;   endtask
  task automatic pulse_menu();   menu = 1'b1; @(negedge clk); menu = 1'b0; endtask
  task automatic pulse_hit(input logic [3:0] v); hit = v; @(negedge clk); hit = 4'd0; endtask
  task automatic tick_main();    vs = 1'b1; @(negedge clk); vs = 1'b0; @(negedge clk); endtask
  task automatic tick_big();     vs2 = 1'b1; @(negedge clk); vs2 = 1'b0; @(negedge clk); endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    ss = 0; sm = 0; menu = 0; vs = 0; oready = 0; oover = 0; hit = 4'd0;
    ss2 = 0; vs2 = 0; zero1 = 0; zero4 = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    chk_en = 1'b1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_hp", 32'(hp), 32'd3);
    chk("reset_flags", 32'({play_active, player_ready, multiplayer, victory, game_over, invuln}), 32'd0);

    // Single-player survival to victory
    pulse_ss();
    chk("play_entry", 32'(state), 32'd2);
    repeat (5) tick_main();
    @(negedge clk);
    chk("win_state", 32'(state), 32'd3);
    chk("win_flag", 32'(victory), 32'd1);
    chk("win_score", 32'(score_bcd), 32'h0005);
    chk("win_hp", 32'(hp), 32'd3);
    pulse_menu();

    // Held multi-bit hit gives one decrement, then invulnerability expires
    pulse_ss();
    hit = 4'b0110;
    repeat (10) @(negedge clk);
    hit = 4'd0;
    chk("held_hit_hp", 32'(hp), 32'd2);
    chk("held_hit_inv", 32'(invuln), 32'd1);
`ifdef GAME_SESSION_CTRL_HIT_LOG_EN
    chk("hit_log_val", 32'(hit_log), 32'b0110);
`endif
    repeat (2) tick_main();
    chk("inv_expired", 32'(invuln), 32'd0);

    // Two more hits separated by two ticks end the game
    pulse_hit(4'b0001);
    chk("hit2_hp", 32'(hp), 32'd1);
    repeat (2) tick_main();
    pulse_hit(4'b1000);
    chk("hit3_hp", 32'(hp), 32'd0);
    @(negedge clk);
    chk("gameover_state", 32'(state), 32'd4);
    chk("gameover_flag", 32'(game_over), 32'd1);
    pulse_ss();
    chk("gameover_ignores_start", 32'(state), 32'd4);
    pulse_menu();
    chk("menu_state", 32'(state), 32'd0);
    chk("menu_flags", 32'({play_active, player_ready, victory, game_over}), 32'd0);

    // Multiplayer flow
    pulse_sm();
    chk("wait_state", 32'(state), 32'd1);
    chk("wait_ready", 32'(player_ready), 32'd1);
    oready = 1'b1; menu = 1'b1;
    @(negedge clk);
    oready = 1'b0; menu = 1'b0;
    chk("wait_menu_wins", 32'(state), 32'd0);
    pulse_sm();
    oready = 1'b1; @(negedge clk); oready = 1'b0;
    chk("mp_play", 32'(state), 32'd2);
    chk("mp_ready", 32'(player_ready), 32'd1);
    oover = 1'b1; @(negedge clk); oover = 1'b0;
    chk("mp_victory", 32'(state), 32'd3);
    pulse_menu();

    // Asynchronous reset in the middle of a game
    pulse_ss();
    pulse_hit(4'b0010);
    repeat (2) tick_main();
    pulse_hit(4'b0100);
    tick_main();
    chk("pre_rst_hp", 32'(hp), 32'd1);
    chk("pre_rst_score", 32'(score_bcd), 32'h0003);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_hp", 32'(hp), 32'd3);
    chk("async_rst_score", 32'(score_bcd), 32'd0);
    chk("async_rst_inv", 32'(invuln), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized play
    repeat (3000) begin
      ss     = ($urandom % 40) == 0;
      sm     = ($urandom % 40) == 0;
      menu   = ($urandom % 60) == 0;
      vs     = 1'($urandom % 2);
      hit    = (($urandom % 8) == 0) ? 4'($urandom % 16) : 4'd0;
      oready = ($urandom % 4) == 0;
      oover  = ($urandom % 30) == 0;
      @(negedge clk);
    end
    ss = 0; sm = 0; menu = 0; vs = 0; hit = 4'd0; oready = 0; oover = 0;

    // Long game: BCD carry and saturation
    ss2 = 1'b1; @(negedge clk); ss2 = 1'b0;
    repeat (99) tick_big();
    chk("big_0099", 32'(score2), 32'h0099);
    tick_big();
    chk("big_0100", 32'(score2), 32'h0100);
    repeat (9899) tick_big();
    chk("big_9999", 32'(score2), 32'h9999);
    repeat (6) tick_big();
    chk("big_sat", 32'(score2), 32'h9999);
    chk("big_state", 32'(state2), 32'd2);
    chk("big_hp", 32'(hp2), 32'd3);
    chk("big_flags", 32'({pa2, pr2, mp2, vic2, go2, inv2}), 32'b100000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
